// File: rtl/rggen_register_command_initiator.sv
// Host-side initiator: takes one host request, drives a register-block
// command until the addressed register completes, then returns data/status.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   i_req_* / o_req_ready       host request channel (valid/ready)
//   o_rsp_* / i_rsp_ready       host response channel (valid/ready)
//   o_command_valid, o_write,
//   o_address, o_write_data,
//   o_write_mask                command toward the bit-field registers
//   i_select, i_ready,
//   i_read_data                 completion from the register block
module rggen_register_command_initiator #(
    parameter int unsigned ADDRESS_WIDTH  = 16,
    parameter int unsigned BUS_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic                     i_req_write,
    input  logic [ADDRESS_WIDTH-1:0] i_req_address,
    input  logic [BUS_WIDTH-1:0]     i_req_write_data,
    input  logic [BUS_WIDTH/8-1:0]   i_req_strobe,
    output logic                     o_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [BUS_WIDTH-1:0]     o_rsp_read_data,
    output logic [1:0]               o_rsp_status,
    output logic                     o_command_valid,
    output logic                     o_write,
    output logic [ADDRESS_WIDTH-1:0] o_address,
    output logic [BUS_WIDTH-1:0]     o_write_data,
    output logic [BUS_WIDTH-1:0]     o_write_mask,
    input  logic                     i_select,
    input  logic                     i_ready,
    input  logic [BUS_WIDTH-1:0]     i_read_data
);

    // A disabled timeout still needs a legal 1-bit counter vector.
    localparam int unsigned CNT_W =
        (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned TMO_LAST_I =
        (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_LAST_I);

    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_DECODE  = 2'b10;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMMAND  = 2'd1,
        RESPONSE = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic                     write_q, write_d;
    logic [ADDRESS_WIDTH-1:0] address_q, address_d;
    logic [BUS_WIDTH-1:0]     write_data_q, write_data_d;
    logic [BUS_WIDTH-1:0]     write_mask_q, write_mask_d;
    logic [BUS_WIDTH-1:0]     read_data_q, read_data_d;
    logic [1:0]               status_q, status_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [BUS_WIDTH-1:0]     strobe_mask;

    always_comb begin
        for (int i = 0; i < int'(BUS_WIDTH); i++) begin
            strobe_mask[i] = i_req_strobe[i/8];
        end
    end

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        address_d    = address_q;
        write_data_d = write_data_q;
        write_mask_d = write_mask_q;
        read_data_d  = read_data_q;
        status_d     = status_q;
        count_d      = count_q;
        unique case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    state_d      = COMMAND;
                    write_d      = i_req_write;
                    address_d    = i_req_address;
                    write_data_d = i_req_write_data;
                    write_mask_d = i_req_write ? strobe_mask : '0;
                    count_d      = '0;
                end
            end
            COMMAND: begin
                if (!i_select) begin
                    state_d     = RESPONSE;
                    status_d    = STATUS_DECODE;
                    read_data_d = '0;
                end else if (i_ready) begin
                    state_d     = RESPONSE;
                    status_d    = STATUS_OK;
                    read_data_d = write_q ? '0 : i_read_data;
                end else if (TIMEOUT_CYCLES != 0 && count_q == TMO_LAST) begin
                    state_d     = RESPONSE;
                    status_d    = STATUS_TIMEOUT;
                    read_data_d = '0;
                end else if (TIMEOUT_CYCLES != 0) begin
                    // Bounded by the timeout compare above, so never wraps.
                    count_d = count_q + 1'b1;
                end
            end
            RESPONSE: begin
                if (i_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            address_q    <= '0;
            write_data_q <= '0;
            write_mask_q <= '0;
            read_data_q  <= '0;
            status_q     <= 2'b00;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            address_q    <= address_d;
            write_data_q <= write_data_d;
            write_mask_q <= write_mask_d;
            read_data_q  <= read_data_d;
            status_q     <= status_d;
            count_q      <= count_d;
        end
    end

    assign o_req_ready     = (state_q == IDLE);
    assign o_rsp_valid     = (state_q == RESPONSE);
    assign o_command_valid = (state_q == COMMAND);
    assign o_write         = write_q;
    assign o_address       = address_q;
    assign o_write_data    = write_data_q;
    assign o_write_mask    = write_mask_q;
    assign o_rsp_read_data = read_data_q;
    assign o_rsp_status    = status_q;

endmodule

// File: tb/tb_rggen_register_command_initiator.sv
// Directed bench for rggen_register_command_initiator.
// dut has a 4-cycle timeout; dut0 shares its inputs with the timeout disabled.
module tb_rggen_register_command_initiator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [15:0] req_address;
    logic [31:0] req_write_data;
    logic [3:0]  req_strobe;
    logic        rsp_ready;
    logic        sel;
    logic        rdy;
    logic [31:0] rdata;

    logic        req_ready, rsp_valid, cmd_valid, wr;
    logic [31:0] rsp_data, wdata, wmask;
    logic [1:0]  rsp_status;
    logic [15:0] addr;

    logic        req_ready0, rsp_valid0, cmd_valid0, wr0;
    logic [31:0] rsp_data0, wdata0, wmask0;
    logic [1:0]  rsp_status0;
    logic [15:0] addr0;

    int total = 0;
    int bad   = 0;
    int ncmd;

    always #5 clk = ~clk;

    rggen_register_command_initiator #(
        .ADDRESS_WIDTH(16), .BUS_WIDTH(32), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_write(req_write), .i_req_address(req_address),
        .i_req_write_data(req_write_data), .i_req_strobe(req_strobe),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_read_data(rsp_data), .o_rsp_status(rsp_status),
        .o_command_valid(cmd_valid), .o_write(wr), .o_address(addr),
        .o_write_data(wdata), .o_write_mask(wmask),
        .i_select(sel), .i_ready(rdy), .i_read_data(rdata)
    );

    rggen_register_command_initiator #(
        .ADDRESS_WIDTH(16), .BUS_WIDTH(32), .TIMEOUT_CYCLES(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready0),
        .i_req_write(req_write), .i_req_address(req_address),
        .i_req_write_data(req_write_data), .i_req_strobe(req_strobe),
        .o_rsp_valid(rsp_valid0), .i_rsp_ready(rsp_ready),
        .o_rsp_read_data(rsp_data0), .o_rsp_status(rsp_status0),
        .o_command_valid(cmd_valid0), .o_write(wr0), .o_address(addr0),
        .o_write_data(wdata0), .o_write_mask(wmask0),
        .i_select(sel), .i_ready(rdy), .i_read_data(rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic w, input logic [15:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        req_valid      = 1'b1;
        req_write      = w;
        req_address    = a;
        req_write_data = d;
        req_strobe     = s;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_address = '0; req_write_data = '0; req_strobe = '0;
        rsp_ready = 1'b0; sel = 1'b0; rdy = 1'b0; rdata = '0;

        // Reset state
        tick(); tick();
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        chk("rst_address",   64'(addr), 64'd0);
        chk("rst_mask",      64'(wmask), 64'd0);
        chk("rst_status",    64'(rsp_status), 64'd0);
        chk("rst_rdata",     64'(rsp_data), 64'd0);
        rst_n = 1'b1;
        tick();

        // Read, register ready in first command cycle
        request(1'b0, 16'h0010, 32'hFFFF_FFFF, 4'hF);
        sel = 1'b1; rdy = 1'b1; rdata = 32'hCAFE_0001;
        tick();
        req_valid = 1'b0;
        chk("rd_cmd_valid", 64'(cmd_valid), 64'd1);
        chk("rd_req_ready", 64'(req_ready), 64'd0);
        chk("rd_address",   64'(addr), 64'h0010);
        chk("rd_write",     64'(wr), 64'd0);
        chk("rd_mask",      64'(wmask), 64'd0);
        tick();
        chk("rd_cmd_drop",  64'(cmd_valid), 64'd0);
        chk("rd_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("rd_rsp_data",  64'(rsp_data), 64'hCAFE_0001);
        chk("rd_rsp_stat",  64'(rsp_status), 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rd_idle_rsp",  64'(rsp_valid), 64'd0);
        chk("rd_idle_rdy",  64'(req_ready), 64'd1);

        // Write with partial strobes, one wait cycle
        request(1'b1, 16'h0004, 32'h1234_5678, 4'b0101);
        rdy = 1'b0;
        tick();
        req_valid = 1'b0;
        chk("wr_cmd_valid", 64'(cmd_valid), 64'd1);
        chk("wr_write",     64'(wr), 64'd1);
        chk("wr_address",   64'(addr), 64'h0004);
        chk("wr_wdata",     64'(wdata), 64'h1234_5678);
        chk("wr_mask",      64'(wmask), 64'h00FF_00FF);
        tick();
        chk("wr_hold_cmd",  64'(cmd_valid), 64'd1);
        chk("wr_hold_mask", 64'(wmask), 64'h00FF_00FF);
        chk("wr_hold_data", 64'(wdata), 64'h1234_5678);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk("wr_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("wr_rsp_data",  64'(rsp_data), 64'd0);
        chk("wr_rsp_stat",  64'(rsp_status), 64'd0);

        // Response stall with a competing request
        request(1'b0, 16'h0030, 32'd0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", 64'(rsp_valid), 64'd1);
            chk("stall_data",  64'(rsp_data), 64'd0);
            chk("stall_stat",  64'(rsp_status), 64'd0);
            chk("stall_rrdy",  64'(req_ready), 64'd0);
            chk("stall_cmd",   64'(cmd_valid), 64'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk("hs_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("hs_req_ready", 64'(req_ready), 64'd1);
        chk("hs_no_accept", 64'(cmd_valid), 64'd0);
        tick();
        chk("hs_still_idle", 64'(cmd_valid), 64'd0);

        // Unmapped address: decode error outranks ready
        request(1'b0, 16'h0F00, 32'd0, 4'h0);
        sel = 1'b0; rdy = 1'b1; rdata = 32'hDEAD_BEEF;
        tick();
        req_valid = 1'b0;
        chk("dec_cmd_valid", 64'(cmd_valid), 64'd1);
        tick();
        chk("dec_cmd_drop", 64'(cmd_valid), 64'd0);
        chk("dec_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("dec_status",   64'(rsp_status), 64'h2);
        chk("dec_data",     64'(rsp_data), 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Timeout: 4 command cycles on dut, dut0 keeps waiting
        request(1'b0, 16'h0020, 32'd0, 4'h0);
        sel = 1'b1; rdy = 1'b0; rdata = 32'hA5A5_0F0F;
        tick();
        req_valid = 1'b0;
        ncmd = 0;
        for (int i = 0; i < 10; i++) begin
            if (cmd_valid) ncmd++;
            tick();
        end
        chk("to_cmd_cycles", 64'(ncmd), 64'd4);
        chk("to_rsp_valid",  64'(rsp_valid), 64'd1);
        chk("to_status",     64'(rsp_status), 64'h3);
        chk("to_data",       64'(rsp_data), 64'd0);
        chk("to0_waiting",   64'(cmd_valid0), 64'd1);
        chk("to0_no_rsp",    64'(rsp_valid0), 64'd0);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        chk("to0_rsp_valid", 64'(rsp_valid0), 64'd1);
        chk("to0_status",    64'(rsp_status0), 64'd0);
        chk("to0_data",      64'(rsp_data0), 64'hA5A5_0F0F);
        chk("to_stat_held",  64'(rsp_status), 64'h3);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("to_idle",       64'(req_ready), 64'd1);
        chk("to0_idle",      64'(req_ready0), 64'd1);

        // Reset in the middle of a command
        request(1'b1, 16'h0008, 32'h0BAD_F00D, 4'hF);
        tick();
        req_valid = 1'b0;
        chk("mr_cmd_valid", 64'(cmd_valid), 64'd1);
        rst_n = 1'b0;
        tick();
        chk("mr_cmd_valid0", 64'(cmd_valid), 64'd0);
        chk("mr_req_ready",  64'(req_ready), 64'd1);
        chk("mr_rsp_valid",  64'(rsp_valid), 64'd0);
        chk("mr_address",    64'(addr), 64'd0);
        chk("mr_write",      64'(wr), 64'd0);
        chk("mr_wdata",      64'(wdata), 64'd0);
        chk("mr_mask",       64'(wmask), 64'd0);
        chk("mr_status",     64'(rsp_status), 64'd0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("mr_no_rsp",     64'(rsp_valid), 64'd0);
        chk("mr_no_cmd",     64'(cmd_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
